mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_responder_fifo.sv | 63 ++++++
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared memory-definitions package for mem_responder.
// Holds the bus op codes, the IO window constants and a small helper that
// classifies an address as IO or RAM.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_NOP  = 2'd0,
    MEM_LOAD = 2'd1,
    MEM_SAVE = 2'd2
  } mem_op_e;

  // IO window lives where address bits [17:16] are both set.
  localparam logic [31:0] IO_DECODE_MASK = 32'h0003_0000;
  // Bits that take part in IO register matching; bits above 17 are ignored.
  localparam logic [31:0] IO_ADDR_MASK   = 32'h0003_FFFF;
  localparam logic [31:0] IO_BASE        = 32'h0003_0000;
  localparam logic [31:0] IO_STATUS_OFF  = 32'h0000_0004;

  function automatic logic is_io_addr(input logic [31:0] addr);
    return (addr & IO_DECODE_MASK) == IO_DECODE_MASK;
  endfunction

endpackage

// File: rtl/mem_responder_fifo.sv
// byte_fifo: small byte FIFO used as the output queue of mem_responder.
// Ports:
//   clk_in, rst_in (async active-low)   clock / reset
//   push, din                           enqueue request and byte
//   pop                                 dequeue request (ignored when empty)
//   dout                                head byte, 8'h00 when empty
//   full, empty, count[4:0]             occupancy status
// A push while full is accepted only when a pop happens on the same edge.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [4:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    store_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (count_q == 5'd0);
    full     = (count_q == 5'(DEPTH));
    do_pop   = pop && !empty;
    // When full, the slot under wr_ptr is the head being popped this edge.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d  = count_q + {4'd0, do_push} - {4'd0, do_pop};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) store_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? 8'h00 : store_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-wide RAM responder with an optional IO window that
// feeds an output byte FIFO.
// Optional feature macro: MEM_RESPONDER_IO_EN (IO decode + FIFO built).
// Ports:
//   clk_in           clock, rising edge
//   rst_in           async active-low reset
//   rdy_in           when low, bus ignored and all state held
//   mem_a[31:0]      byte address
//   mem_wr           1 = write, 0 = read
//   mem_dout[7:0]    write data
//   mem_din[7:0]     registered read data (one-cycle latency)
//   out_valid        FIFO non-empty
//   out_data[7:0]    FIFO head byte
//   out_ready        consumer accepts head byte
// IO map: 0x30000 write pushes into the FIFO; 0x30004 read returns
// {overflow, full, 1'b0, count[4:0]} and clears overflow.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready
);

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  mem_op_e               op;
  logic                  io_sel;
  logic [7:0]            io_rdata;
  logic [7:0]            mem_din_q, mem_din_d;
  logic                  unused_addr;

  always_comb begin
    op = MEM_NOP;
    if (rdy_in) op = mem_wr ? MEM_SAVE : MEM_LOAD;
  end

`ifdef MEM_RESPONDER_IO_EN
  logic       overflow_q, overflow_d;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [4:0] fifo_count;
  logic [7:0] fifo_head;
  logic       hit_data, hit_status;

  assign io_sel      = is_io_addr(mem_a);
  assign hit_data    = (mem_a & IO_ADDR_MASK) == IO_BASE;
  assign hit_status  = (mem_a & IO_ADDR_MASK) == (IO_BASE + IO_STATUS_OFF);
  assign unused_addr = ^mem_a;

  always_comb begin
    fifo_push  = (op == MEM_SAVE) && io_sel && hit_data;
    // byte_fifo itself ignores a pop while empty.
    fifo_pop   = rdy_in && out_ready;
    io_rdata   = 8'h00;
    if (hit_status) io_rdata = {overflow_q, fifo_full, 1'b0, fifo_count};
    overflow_d = overflow_q;
    if (fifo_push && fifo_full && !fifo_pop)          overflow_d = 1'b1;
    if ((op == MEM_LOAD) && io_sel && hit_status)     overflow_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_byte_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (mem_dout),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;
`else
  assign io_sel      = 1'b0;
  assign io_rdata    = 8'h00;
  assign out_valid   = 1'b0;
  assign out_data    = 8'h00;
  assign unused_addr = ^{mem_a, out_ready};
`endif

  always_comb begin
    ram_addr  = mem_a[ADDR_WIDTH-1:0];
    // Gated by reset so a write in flight when reset lands is discarded.
    ram_we    = (op == MEM_SAVE) && !io_sel && rst_in;
    mem_din_d = mem_din_q;
    if (op == MEM_LOAD) mem_din_d = io_sel ? io_rdata : ram[ram_addr];
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= mem_dout;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) mem_din_q <= 8'h00;
    else         mem_din_q <= mem_din_d;
  end

  assign mem_din = mem_din_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a random
// phase, all checked against a queue/array reference model.
module tb_mem_responder;

`ifdef MEM_RESPONDER_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif
  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  mem_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] m_ram [int];
  logic [7:0] m_q [$];
  bit         m_ovf;
  logic [7:0] m_din;
  bit         m_din_known;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    if (m_din_known) chk("mem_din", 32'(mem_din), 32'(m_din));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    chk("out_data", 32'(out_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
  endtask

  // One bus cycle: drive, advance model, clock, compare.
  task automatic step(input bit wr, input logic [31:0] a, input logic [7:0] d,
                      input bit rdy, input bit ordy);
    int  sz;
    bit  is_io, popped, push_ok;
    mem_wr = wr; mem_a = a; mem_dout = d; rdy_in = rdy; out_ready = ordy;
    sz      = m_q.size();
    is_io   = IO_EN && (a[17:16] == 2'b11);
    popped  = 1'b0;
    push_ok = 1'b0;
    if (rdy) begin
      popped = ordy && (sz > 0);
      if (wr) begin
        if (!is_io) m_ram[int'(a[16:0])] = d;
        else if (a[17:0] == 18'h30000) begin
          if (sz < DEPTH || popped) push_ok = 1'b1;
          else m_ovf = 1'b1;
        end
      end else begin
        if (is_io) begin
          m_din_known = 1'b1;
          if (a[17:0] == 18'h30004) begin
            m_din = {m_ovf, (sz == DEPTH), 1'b0, 5'(sz)};
            m_ovf = 1'b0;
          end else m_din = 8'h00;
        end else if (m_ram.exists(int'(a[16:0]))) begin
          m_din_known = 1'b1;
          m_din = m_ram[int'(a[16:0])];
        end else m_din_known = 1'b0;
      end
      if (popped) void'(m_q.pop_front());
      if (push_ok) m_q.push_back(d);
    end
    @(posedge clk_in); #1;
    check_outputs();
  endtask

  task automatic reset_pulse();
    rdy_in = 1'b0; out_ready = 1'b0; mem_wr = 1'b0;
    rst_in = 1'b0;
    #2;
    m_q.delete(); m_ovf = 1'b0; m_din = 8'h00; m_din_known = 1'b1;
    chk("rst_mem_din", 32'(mem_din), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    @(posedge clk_in); #1;
    chk("rst_hold_valid", 32'(out_valid), 32'h0);
    rst_in = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] popped_bytes [$];
    logic [31:0] a;
    rst_in = 1'b0; rdy_in = 1'b0; mem_a = '0; mem_wr = 1'b0;
    mem_dout = '0; out_ready = 1'b0;
    m_ovf = 1'b0; m_din = 8'h00; m_din_known = 1'b1;
    #12;
    chk("reset_mem_din", 32'(mem_din), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // Single write then read
    step(1, 32'h0001_0, 8'hA5, 1, 0);
    step(0, 32'h0001_0, 8'h00, 1, 0);
    chk("wr_rd_A5", 32'(mem_din), 32'hA5);

    // Four writes, back-to-back reads
    for (int i = 0; i < 4; i++) step(1, 32'h100 + i, 8'(8'h11 * (i + 1)), 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h100 + i, 8'h00, 1, 0);
      chk("b2b_read", 32'(mem_din), 32'(8'h11 * (i + 1)));
    end

    // rdy_in low blocks a write; read returns the previous byte
    step(1, 32'h20, 8'h3C, 1, 0);
    step(1, 32'h20, 8'h77, 0, 0);
    step(0, 32'h20, 8'h00, 1, 0);
    chk("rdy_low_write", 32'(mem_din), 32'h3C);

    // Nine pushes with consumer stalled, then two status reads
    for (int i = 1; i <= 9; i++) step(1, 32'h30000, 8'(i), 1, 0);
    step(0, 32'h30004, 8'h00, 1, 0);
`ifdef MEM_RESPONDER_IO_EN
    chk("status_ovf", 32'(mem_din), 32'hC8);
`endif
    step(0, 32'h30004, 8'h00, 1, 0);
`ifdef MEM_RESPONDER_IO_EN
    chk("status_clr", 32'(mem_din), 32'h48);
`endif

    // Full FIFO: push and pop on the same edge
    step(1, 32'h30000, 8'h5A, 1, 1);
    step(0, 32'h30004, 8'h00, 1, 0);
`ifdef MEM_RESPONDER_IO_EN
    chk("push_pop_full", 32'(mem_din), 32'h48);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      popped_bytes.push_back(out_data);
      step(0, 32'h100, 8'h00, 1, 1);
    end
`ifdef MEM_RESPONDER_IO_EN
    chk("last_popped", 32'(popped_bytes[DEPTH-1]), 32'h5A);
    chk("first_popped", 32'(popped_bytes[0]), 32'h02);
`endif

    // Reset with three bytes queued
    for (int i = 0; i < 3; i++) step(1, 32'h30000, 8'hC0 + 8'(i), 1, 0);
    reset_pulse();
    step(0, 32'h30004, 8'h00, 1, 0);
`ifdef MEM_RESPONDER_IO_EN
    chk("status_after_rst", 32'(mem_din), 32'h00);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = {14'($urandom), 18'($urandom_range(0, 7))};
        3:       a = {14'($urandom), 18'h30000};
        4:       a = {14'($urandom), 18'h30004};
        default: a = {14'($urandom), 18'h30008};
      endcase
      step(1'($urandom_range(0, 1)), a, 8'($urandom),
           ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)));
      if (n == 200) reset_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
